// File: rtl/pc_gen.sv
// Program-counter generator feeding a registered-address instruction memory.
// Tracks the PC/validity of the instruction the fetch stage is presenting.
module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 11,
    parameter logic [31:0] PC_INC   = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_next,
    output logic        fetch_valid,
    output logic        addr_err,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] count_q, count_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        addr_err_q, addr_err_d;

    logic        load_en;
    logic [31:0] load_pc;
    logic        load_valid;
    logic [31:0] seq_pc;

    assign seq_pc = pc_q + PC_INC;

    function automatic logic out_of_range(input logic [31:0] a);
        return (a >> ADDR_W) != 32'd0;
    endfunction

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        addr_err_d    = addr_err_q;
        count_d       = count_q;
        load_en       = 1'b0;
        load_pc       = seq_pc;
        load_valid    = 1'b1;

        case (state_q)
            StBoot: begin
                load_en = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                // The presented instruction is consumed whenever it is valid and not held.
                if (fetch_valid_q && !stall) begin
                    count_d = count_q + 32'd1;
                end
                if (redirect) begin
                    load_en    = 1'b1;
                    load_pc    = redirect_pc;
                    load_valid = 1'b0;
                end else if (halt) begin
                    fetch_valid_d = 1'b0;
                    state_d       = StHalt;
                end else if (!stall) begin
                    load_en = 1'b1;
                end
            end
            StHalt: begin
                fetch_valid_d = 1'b0;
            end
            default: begin
                state_d = StHalt;
            end
        endcase

        if (load_en) begin
            fetch_pc_d = pc_q;
            pc_d       = load_pc;
            if (out_of_range(load_pc)) begin
                addr_err_d    = 1'b1;
                fetch_valid_d = 1'b0;
                state_d       = StHalt;
            end else begin
                fetch_valid_d = load_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            fetch_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            count_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            addr_err_q    <= addr_err_d;
            count_q       <= count_d;
        end
    end

    assign pc            = pc_q;
    assign fetch_pc      = fetch_pc_q;
    assign fetch_pc_next = fetch_pc_q + PC_INC;
    assign fetch_valid   = fetch_valid_q;
    assign addr_err      = addr_err_q;
    assign halted        = (state_q == StHalt);
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// against a behavioural model of the PC stage.
module tb_pc_gen;

    localparam int unsigned ADDR_W = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] pc, fetch_pc, fetch_pc_next, fetch_count;
    logic        fetch_valid, addr_err, halted;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_fpc, m_count;
    logic        m_fv, m_err, m_halted, m_booted;

    pc_gen #(
        .RESET_PC(32'h0000_0000),
        .ADDR_W  (ADDR_W),
        .PC_INC  (32'd1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .pc           (pc),
        .fetch_pc     (fetch_pc),
        .fetch_pc_next(fetch_pc_next),
        .fetch_valid  (fetch_valid),
        .addr_err     (addr_err),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 32'd0; m_fpc = 32'd0; m_count = 32'd0;
        m_fv = 1'b0; m_err = 1'b0; m_halted = 1'b0; m_booted = 1'b0;
    endtask

    task automatic model_load(input logic [31:0] target, input logic valid);
        m_fpc = m_pc;
        m_pc  = target;
        if (target >= (32'd1 << ADDR_W)) begin
            m_err = 1'b1; m_halted = 1'b1; m_fv = 1'b0;
        end else begin
            m_fv = valid;
        end
    endtask

    // Apply inputs for one clock edge and advance the model; returns 1 ns after the edge.
    task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic h);
        stall = s; redirect = r; redirect_pc = rp; halt = h;
        @(posedge clk);
        if (!m_halted) begin
            if (!m_booted) begin
                m_booted = 1'b1;
                model_load(m_pc + 32'd1, 1'b1);
            end else begin
                if (m_fv && !s) m_count = m_count + 32'd1;
                if (r) model_load(rp, 1'b0);
                else if (h) begin m_fv = 1'b0; m_halted = 1'b1; end
                else if (!s) model_load(m_pc + 32'd1, 1'b1);
            end
        end
        #1;
        stall = 1'b0; redirect = 1'b0; halt = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (pc !== 32'd0 || fetch_pc !== 32'd0 || fetch_valid !== 1'b0 || addr_err !== 1'b0 ||
            halted !== 1'b0 || fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: pc=%h fpc=%h fv=%b err=%b halted=%b cnt=%0d required all zero",
                     pc, fetch_pc, fetch_valid, addr_err, halted, fetch_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        step(1'b1, 1'b1, 32'h5555, 1'b1);  // BOOT ignores all controls
        checks++;
        if (pc !== 32'd1 || fetch_pc !== 32'd0 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL boot: pc=%h fpc=%h fv=%b required 1 0 1", pc, fetch_pc, fetch_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            checks++;
            if (pc !== m_pc || fetch_pc !== m_fpc || fetch_pc_next !== m_fpc + 32'd1) begin
                errors++;
                $display("FAIL seq_pc: pc=%h fpc=%h next=%h required %h %h %h",
                         pc, fetch_pc, fetch_pc_next, m_pc, m_fpc, m_fpc + 32'd1);
            end
        end
        checks++;
        if (fetch_count !== 32'd3 || pc !== 32'd4) begin
            errors++;
            $display("FAIL seq_count: cnt=%0d pc=%h required 3 4", fetch_count, pc);
        end
    endtask

    task automatic test_stall();
        step(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0);
            checks++;
            if (pc !== 32'd5 || fetch_pc !== 32'd4 || fetch_valid !== 1'b1 ||
                fetch_count !== m_count) begin
                errors++;
                $display("FAIL stall_hold: pc=%h fpc=%h fv=%b cnt=%0d required 5 4 1 %0d",
                         pc, fetch_pc, fetch_valid, fetch_count, m_count);
            end
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (pc !== 32'd6 || fetch_pc !== 32'd5 || fetch_count !== m_count) begin
            errors++;
            $display("FAIL stall_resume: pc=%h fpc=%h cnt=%0d required 6 5 %0d",
                     pc, fetch_pc, fetch_count, m_count);
        end
    endtask

    task automatic test_redirect();
        while (m_pc != 32'd8 && m_pc < 32'd8) step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0);
        checks++;
        if (pc !== 32'h40 || fetch_valid !== 1'b0 || fetch_pc !== 32'd8) begin
            errors++;
            $display("FAIL redirect_edge: pc=%h fv=%b fpc=%h required 40 0 8",
                     pc, fetch_valid, fetch_pc);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (pc !== 32'h41 || fetch_valid !== 1'b1 || fetch_pc !== 32'h40) begin
            errors++;
            $display("FAIL redirect_follow: pc=%h fv=%b fpc=%h required 41 1 40",
                     pc, fetch_valid, fetch_pc);
        end
    endtask

    task automatic test_redirect_stall();
        step(1'b1, 1'b1, 32'h20, 1'b0);
        checks++;
        if (pc !== 32'h20 || fetch_valid !== 1'b0 || fetch_count !== m_count) begin
            errors++;
            $display("FAIL redirect_over_stall: pc=%h fv=%b cnt=%0d required 20 0 %0d",
                     pc, fetch_valid, fetch_count, m_count);
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 40 && m_pc != 32'h10; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        checks++;
        if (halted !== 1'b1 || pc !== 32'h10 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: halted=%b pc=%h fv=%b required 1 10 0", halted, pc, fetch_valid);
        end
        step(1'b0, 1'b1, 32'h77, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (halted !== 1'b1 || pc !== 32'h10 || fetch_valid !== 1'b0 || fetch_pc !== m_fpc ||
            fetch_count !== m_count) begin
            errors++;
            $display("FAIL halt_hold: halted=%b pc=%h fv=%b fpc=%h cnt=%0d required 1 10 0 %h %0d",
                     halted, pc, fetch_valid, fetch_pc, fetch_count, m_fpc, m_count);
        end
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (pc !== 32'd0 || halted !== 1'b0 || fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL midrun_reset: pc=%h halted=%b cnt=%0d required 0 0 0", pc, halted, fetch_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_addr_err();
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h7FF, 1'b0);
        checks++;
        if (addr_err !== 1'b0 || halted !== 1'b0 || pc !== 32'h7FF) begin
            errors++;
            $display("FAIL top_legal_pc: err=%b halted=%b pc=%h required 0 0 7ff", addr_err, halted, pc);
        end
        step(1'b0, 1'b1, 32'h800, 1'b0);
        checks++;
        if (addr_err !== 1'b1 || halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 32'h800) begin
            errors++;
            $display("FAIL addr_err_set: err=%b halted=%b fv=%b pc=%h required 1 1 0 800",
                     addr_err, halted, fetch_valid, pc);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h4, 1'b0);
        checks++;
        if (addr_err !== 1'b1 || pc !== 32'h800) begin
            errors++;
            $display("FAIL addr_err_sticky: err=%b pc=%h required 1 800", addr_err, pc);
        end
        do_reset();
        checks++;
        if (addr_err !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL addr_err_clear: err=%b halted=%b required 0 0", addr_err, halted);
        end
        // Sequential run past the top of memory
        step(1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h7FE, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (addr_err !== m_err || halted !== m_halted || pc !== m_pc || m_err !== 1'b1) begin
            errors++;
            $display("FAIL seq_overflow: err=%b halted=%b pc=%h required %b %b %h",
                     addr_err, halted, pc, m_err, m_halted, m_pc);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic        s, r, h;
        logic [31:0] rp;
        for (int i = 0; i < 600; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) begin
                do_reset();
            end
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 7) == 0);
            h  = ($urandom_range(0, 39) == 0);
            rp = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 2047));
            step(s, r, rp, h);
            checks++;
            if (pc !== m_pc || fetch_pc !== m_fpc || fetch_pc_next !== m_fpc + 32'd1 ||
                fetch_valid !== m_fv || addr_err !== m_err || halted !== m_halted ||
                fetch_count !== m_count) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h fpc=%h nxt=%h fv=%b err=%b h=%b cnt=%0d required %h %h %h %b %b %b %0d",
                         i, pc, fetch_pc, fetch_pc_next, fetch_valid, addr_err, halted, fetch_count,
                         m_pc, m_fpc, m_fpc + 32'd1, m_fv, m_err, m_halted, m_count);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_halt();
        test_addr_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
